// File: rtl/prb_fsync_rd_if.sv
// Reference-sample stream from the fsync ROM read sequencer to the correlator.
interface prb_fsync_rd_if #(
  parameter int DAT_W = 24
);
  logic [DAT_W-1:0] m_dat;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (output m_dat, output m_valid, output m_last, input m_ready);
  modport slave  (input m_dat, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/prb_fsync_rd_ctrl.sv
// Read sequencer for the preamble frequency-sync reference ROM: latches a band,
// waits for the band offset to settle, then streams one segment through a small FIFO.
module prb_fsync_rd_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int DAT_W      = 24,
  parameter int SEG_LEN    = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [2:0]        i_index_bw,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [2:0]        o_rom_index_bw,
  input  logic [DAT_W-1:0]  i_rom_dat,
  prb_fsync_rd_if.master    m_if,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_bw
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [2:0]        MAX_BW    = 3'd5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEG_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SC_W-1:0]   r_setup_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_index_bw;
  logic              r_in_flight;
  logic              r_in_flight_last;
  logic [DAT_W:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_done;
  logic              r_err_bw;

  logic w_accept;
  logic w_reject;
  logic w_issue;
  logic w_done_evt;
  logic w_push;
  logic w_pop;
  logic w_can_issue;
  logic w_addr_last;
  logic w_head_last;
  logic w_valid;

  // Credit check counts the read still in flight so the FIFO can never overflow.
  assign w_can_issue = (r_count + CNT_W'(r_in_flight)) < CNT_W'(FIFO_DEPTH);
  assign w_addr_last = (r_addr == LAST_ADDR);
  assign w_valid     = (r_count != '0);
  assign w_head_last = r_mem[r_rd_ptr][DAT_W];
  assign w_pop       = w_valid & m_if.m_ready;
  assign w_push      = r_in_flight & ~i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_issue     = 1'b0;
    w_done_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_index_bw <= MAX_BW) begin
            w_accept    = 1'b1;
            w_state_nxt = S_SETUP;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (r_setup_cnt == '0) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_can_issue) begin
          w_issue = 1'b1;
          if (w_addr_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_done_evt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_issue     = 1'b0;
      w_done_evt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_setup_cnt      <= '0;
      r_addr           <= '0;
      r_index_bw       <= MAX_BW;
      r_in_flight      <= 1'b0;
      r_in_flight_last <= 1'b0;
      r_done           <= 1'b0;
      r_err_bw         <= 1'b0;
    end else begin
      r_done           <= w_done_evt;
      r_err_bw         <= w_reject;
      r_in_flight      <= w_issue;
      r_in_flight_last <= w_issue & w_addr_last;
      if (w_accept) r_index_bw <= i_index_bw;
      if (w_accept) begin
        r_setup_cnt <= SC_W'(SETUP_CYC - 1);
      end else if (r_state == S_SETUP && r_setup_cnt != '0) begin
        r_setup_cnt <= r_setup_cnt - SC_W'(1);
      end
      // Address shows the next read to issue; parks at the last address while draining.
      if (w_state_nxt == S_IDLE) begin
        r_addr <= '0;
      end else if (w_issue && !w_addr_last) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_in_flight_last, i_rom_dat};
  end

  assign m_if.m_valid   = w_valid;
  assign m_if.m_dat     = r_mem[r_rd_ptr][DAT_W-1:0];
  assign m_if.m_last    = w_valid & w_head_last;
  assign o_rom_addr     = r_addr;
  assign o_rom_index_bw = r_index_bw;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_err_bw       = r_err_bw;
endmodule
